// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: activation width, the signed activation type,
// the row-parity state encoding, and the small ReLU/max helpers.
package cnn_pkg;

  localparam int DATA_W = 32;

  typedef logic signed [DATA_W-1:0] act_t;

  typedef enum logic {
    ROW_EVEN = 1'b0,
    ROW_ODD  = 1'b1
  } row_state_e;

  function automatic act_t act_relu(input act_t a);
    return a[DATA_W-1] ? act_t'(0) : a;
  endfunction

  // Both operands are act_t, so the comparison is signed at DATA_W bits.
  function automatic act_t act_max(input act_t a, input act_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_relu_stream_if.sv
// Valid/ready stream bundle for the pooling block: a conv pixel input side
// and a pooled pixel output side with an end-of-frame marker.
interface pool_relu_stream_if
  import cnn_pkg::*;
();

  logic in_valid;
  logic in_ready;
  act_t in_data;
  logic out_valid;
  logic out_ready;
  act_t out_data;
  logic out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/pool_line_buf.sv
// Half-width line buffer holding the horizontal pair maxima of the even row:
// one synchronous write port, one asynchronous read port.
module pool_line_buf
  import cnn_pkg::*;
#(
  parameter int DEPTH = 112,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  act_t          i_wdata,
  input  logic [AW-1:0] i_raddr,
  output act_t          o_rdata
);

  act_t r_mem [DEPTH];

  // NOTE: storage has no reset; every entry is written on the even row before
  // the odd row reads it, so a reset would only cost flops and routing.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pool_relu_stream.sv
// Streaming ReLU followed by 2x2 max pooling over a raster-order frame;
// emits one pooled pixel per completed 2x2 block with a 1-cycle latency.
module pool_relu_stream
  import cnn_pkg::*;
#(
  parameter int IMG_W = 224,
  parameter int IMG_H = 224
) (
  input logic              clk,
  input logic              rst_n,
  pool_relu_stream_if.slave bus
);

  localparam int COL_W    = $clog2(IMG_W);
  localparam int ROW_W    = $clog2(IMG_H);
  localparam int LB_DEPTH = IMG_W / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  row_state_e       r_state;
  row_state_e       w_state_nxt;
  act_t             r_pair;
  logic             r_out_valid;
  logic             r_out_last;
  act_t             r_out_data;

  logic             w_in_ready;
  logic             w_beat;
  logic             w_col_last;
  logic             w_row_last;
  logic             w_col_odd;
  logic             w_lb_we;
  logic             w_out_load;
  logic [LB_AW-1:0] w_lb_addr;
  act_t             w_relu;
  act_t             w_pair_max;
  act_t             w_lb_rdata;

  assign w_in_ready = !(r_out_valid && !bus.out_ready);
  assign w_beat     = bus.in_valid && w_in_ready;
  assign w_col_last = (r_col == COL_W'(IMG_W - 1));
  assign w_row_last = (r_row == ROW_W'(IMG_H - 1));
  assign w_col_odd  = r_col[0];
  assign w_lb_addr  = LB_AW'(r_col >> 1);
  assign w_relu     = act_relu(bus.in_data);
  assign w_pair_max = act_max(r_pair, w_relu);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_beat) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ROW_EVEN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_lb_we     = 1'b0;
    w_out_load  = 1'b0;
    if (w_beat && w_col_odd) begin
      case (r_state)
        ROW_EVEN: w_lb_we    = 1'b1;
        ROW_ODD:  w_out_load = 1'b1;
        default:  ;
      endcase
    end
    if (w_beat && w_col_last) begin
      w_state_nxt = (r_state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pair <= '0;
    end else if (w_beat && !w_col_odd) begin
      r_pair <= w_relu;
    end
  end

  pool_line_buf #(
    .DEPTH (LB_DEPTH),
    .AW    (LB_AW)
  ) u_line_buf (
    .clk     (clk),
    .i_we    (w_lb_we),
    .i_waddr (w_lb_addr),
    .i_wdata (w_pair_max),
    .i_raddr (w_lb_addr),
    .o_rdata (w_lb_rdata)
  );

  // A completing beat can only arrive while in_ready is high, so a load never
  // overwrites a stalled result; load has priority over the drain clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_out_load) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_row_last && w_col_last;
      r_out_data  <= act_max(w_pair_max, w_lb_rdata);
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_pool_relu_stream.sv
// Directed bench for pool_relu_stream on a 4x4 frame: hand-computed pooled
// outputs, stall, mid-frame reset and back-to-back frame scenarios.
module tb_pool_relu_stream;
  import cnn_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pool_relu_stream_if bus ();

  pool_relu_stream #(
    .IMG_W (4),
    .IMG_H (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  act_t q_data [$];
  bit   q_last [$];
  int   n_in_ready_low = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        q_data.push_back(bus.out_data);
        q_last.push_back(bus.out_last);
      end
      if (!bus.in_ready) n_in_ready_low++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one pixel and returns #1 after the edge that accepted it,
  // leaving in_valid high so a following call continues without a gap.
  task automatic send(input act_t v);
    bit accepted = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    for (int k = 0; k < 100 && !accepted; k++) begin
      @(negedge clk);
      accepted = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: observed in_ready stuck low, expected acceptance");
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_data  = 32'sd999;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outputs(input string tag, input int mark, input int exp[8], input int n);
    check({tag, "_count"}, 64'(q_data.size() - mark), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (mark + i < q_data.size()) begin
        check($sformatf("%s_data%0d", tag, i), 64'(q_data[mark+i]), 64'(act_t'(exp[i])));
        check($sformatf("%s_last%0d", tag, i), 64'(q_last[mark+i]), 64'((i % 4) == 3));
      end
    end
  endtask

  initial begin
    int   mark;
    int   low_mark;
    act_t row1 [4];
    bit   seen;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_last",  64'(bus.out_last),  64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ramp 1..16, continuous, plus first-output latency.
    mark     = q_data.size();
    low_mark = n_in_ready_low;
    for (int i = 1; i <= 6; i++) send(act_t'(i));
    check("ramp_lat_valid", 64'(bus.out_valid), 64'd1);
    check("ramp_lat_data",  64'(bus.out_data),  64'd6);
    for (int i = 7; i <= 16; i++) send(act_t'(i));
    idle(3);
    check_outputs("ramp", mark, '{6, 8, 14, 16, 0, 0, 0, 0}, 4);
    check("ramp_in_ready_high", 64'(n_in_ready_low - low_mark), 64'd0);

    // All -7 with idle gaps carrying garbage data.
    mark = q_data.size();
    for (int i = 0; i < 16; i++) begin
      send(-32'sd7);
      idle(1);
    end
    idle(2);
    check_outputs("neg", mark, '{0, 0, 0, 0, 0, 0, 0, 0}, 4);

    // Signed extremes in row 1.
    mark = q_data.size();
    row1 = '{-32'sd5, 32'sd3, 32'sh7FFF_FFFF, -32'sd1};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        send((r == 1) ? row1[c] : -32'sd2);
    idle(3);
    check_outputs("mix", mark, '{3, 32'h7FFF_FFFF, 0, 0, 0, 0, 0, 0}, 4);

    // Output stall right after the first pooled pixel.
    mark = q_data.size();
    fork
      begin
        for (int i = 1; i <= 16; i++) send(act_t'(i));
        idle(3);
      end
      begin
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
          @(posedge clk);
          #1;
          seen = bus.out_valid;
        end
        if (!seen) begin
          n_tests++;
          n_fail++;
          $display("FAIL stall_wait: observed no out_valid, expected one");
        end
        bus.out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_out_valid", 64'(bus.out_valid), 64'd1);
          check("stall_out_data",  64'(bus.out_data),  64'd6);
          check("stall_in_valid",  64'(bus.in_valid),  64'd1);
          check("stall_in_ready",  64'(bus.in_ready),  64'd0);
          @(posedge clk);
        end
        #1;
        bus.out_ready = 1'b1;
      end
    join
    idle(3);
    check_outputs("stall", mark, '{6, 8, 14, 16, 0, 0, 0, 0}, 4);

    // Reset after six beats of a partial frame.
    mark = q_data.size();
    for (int i = 0; i < 6; i++) send(act_t'(100 + i));
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_out_data",  64'(bus.out_data),  64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 16; i++) send(act_t'(i));
    idle(3);
    check_outputs("midrst", mark, '{6, 8, 14, 16, 0, 0, 0, 0}, 4);

    // Two frames back to back with no gap.
    mark = q_data.size();
    for (int i = 1; i <= 32; i++) send(act_t'(i));
    idle(3);
    check_outputs("b2b", mark, '{6, 8, 14, 16, 22, 24, 30, 32}, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
